comparator_seq: RTL and testbench



---
 rtl/comparator_seq_if.sv | 24 ++
 rtl/comparator_seq.sv | 114 +++++++++++
 tb/tb_comparator_seq.sv | 117 +++++++++++
 3 files changed

// File: rtl/comparator_seq_if.sv
// rtl/comparator_seq_if.sv - req/fin handshake bundle for the sequential magnitude comparator
interface comparator_seq_if #(
  parameter int Width = 32
);
  logic             req;
  logic             sgn;
  logic [Width-1:0] x;
  logic [Width-1:0] y;
  logic             fin;
  logic             busy;
  logic             bigger;
  logic             equal;
  logic             smaller;

  modport master (
    output req, sgn, x, y,
    input  fin, busy, bigger, equal, smaller
  );

  modport slave (
    input  req, sgn, x, y,
    output fin, busy, bigger, equal, smaller
  );
endinterface

// File: rtl/comparator_seq.sv
// rtl/comparator_seq.sv - chunk-serial MSB-first magnitude comparator, unsigned or two's complement
module comparator_seq #(
  parameter int Width = 32,
  parameter int Digit = 8
) (
  input  logic             clk,
  input  logic             rst,
  comparator_seq_if.slave  bus
);
  localparam int C  = (Width + Digit - 1) / Digit;
  localparam int PW = C * Digit;
  localparam int IW = (C > 1) ? $clog2(C) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_q;
  logic [C-1:0][Digit-1:0]  x_q;
  logic [C-1:0][Digit-1:0]  y_q;
  logic [IW-1:0]            idx_q;
  logic                     fin_q;
  logic                     busy_q;
  logic [2:0]               res_q;

  logic [Width-1:0] x_s, y_s;
  logic [PW-1:0]    x_d, y_d;
  logic [Digit-1:0] x_chunk, y_chunk;

  // Flipping the sign bit maps two's complement order onto unsigned order;
  // padding above Width-1 is zero so the top chunk still compares correctly.
  always_comb begin
    x_s = bus.x;
    y_s = bus.y;
    if (bus.sgn) begin
      x_s[Width-1] = ~x_s[Width-1];
      y_s[Width-1] = ~y_s[Width-1];
    end
    x_d = '0;
    y_d = '0;
    x_d[Width-1:0] = x_s;
    y_d[Width-1:0] = y_s;
  end

  always_comb begin
    x_chunk = x_q[idx_q];
    y_chunk = y_q[idx_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
      res_q   <= 3'b000;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req) begin
            x_q     <= x_d;
            y_q     <= y_d;
            idx_q   <= IW'(C - 1);
            res_q   <= 3'b000;
            busy_q  <= 1'b1;
            state_q <= CMP;
          end
        end
        CMP: begin
          if (x_chunk > y_chunk) begin
            res_q   <= 3'b100;
            fin_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else if (x_chunk < y_chunk) begin
            res_q   <= 3'b001;
            fin_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else if (idx_q == '0) begin
            res_q   <= 3'b010;
            fin_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q - 1'b1;
          end
        end
        DONE: begin
          // Flags stay held after the handshake closes; only a new capture clears them.
          if (!bus.req) begin
            fin_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          fin_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fin     = fin_q;
  assign bus.busy    = busy_q;
  assign bus.bigger  = res_q[2];
  assign bus.equal   = res_q[1];
  assign bus.smaller = res_q[0];
endmodule

// File: tb/tb_comparator_seq.sv
// tb/tb_comparator_seq.sv - directed bench for comparator_seq in 32/8 and 12/5 configurations
module tb_comparator_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  comparator_seq_if #(.Width(32)) ifa ();
  comparator_seq_if #(.Width(12)) ifb ();

  comparator_seq #(.Width(32), .Digit(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  comparator_seq #(.Width(12), .Digit(5)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic fin_of(input bit b);
    return b ? ifb.fin : ifa.fin;
  endfunction

  function automatic logic busy_of(input bit b);
    return b ? ifb.busy : ifa.busy;
  endfunction

  function automatic logic [2:0] flags_of(input bit b);
    return b ? {ifb.bigger, ifb.equal, ifb.smaller} : {ifa.bigger, ifa.equal, ifa.smaller};
  endfunction

  task automatic run(input bit bsel, input logic [31:0] xv, input logic [31:0] yv, input bit s,
                     input bit flip, input bit drop, input bit hold,
                     input logic [2:0] exp_res, input int exp_n);
    int n;
    int busyc;
    @(negedge clk);
    if (bsel) begin
      ifb.req = 1'b1; ifb.x = xv[11:0]; ifb.y = yv[11:0]; ifb.sgn = s;
    end else begin
      ifa.req = 1'b1; ifa.x = xv; ifa.y = yv; ifa.sgn = s;
    end
    @(posedge clk); #1;
    chk("busy_after_capture", 32'(busy_of(bsel)), 1);
    chk("flags_after_capture", 32'(flags_of(bsel)), 0);
    if (flip) begin
      if (bsel) ifb.x = ~ifb.x; else ifa.x = ~ifa.x;
    end
    if (drop) begin
      if (bsel) ifb.req = 1'b0; else ifa.req = 1'b0;
    end
    n = 0;
    busyc = 1;
    while (!fin_of(bsel) && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (!fin_of(bsel) && busy_of(bsel)) busyc++;
    end
    chk("latency", 32'(n), 32'(exp_n));
    chk("result", 32'(flags_of(bsel)), 32'(exp_res));
    chk("busy_cycles", 32'(busyc), 32'(exp_n));
    chk("busy_at_fin", 32'(busy_of(bsel)), 0);
    if (hold) begin
      repeat (2) begin
        @(posedge clk); #1;
      end
      chk("hold_fin", 32'(fin_of(bsel)), 1);
      chk("hold_busy", 32'(busy_of(bsel)), 0);
    end
    @(negedge clk);
    if (bsel) ifb.req = 1'b0; else ifa.req = 1'b0;
    @(posedge clk); #1;
    chk("fin_release", 32'(fin_of(bsel)), 0);
    chk("flags_held", 32'(flags_of(bsel)), 32'(exp_res));
  endtask

  initial begin
    ifa.req = 1'b0; ifa.sgn = 1'b0; ifa.x = '0; ifa.y = '0;
    ifb.req = 1'b0; ifb.sgn = 1'b0; ifb.x = '0; ifb.y = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fin_a", 32'(ifa.fin), 0);
    chk("rst_busy_a", 32'(ifa.busy), 0);
    chk("rst_flags_a", 32'(flags_of(1'b0)), 0);
    chk("rst_fin_b", 32'(ifb.fin), 0);
    chk("rst_busy_b", 32'(ifb.busy), 0);
    chk("rst_flags_b", 32'(flags_of(1'b1)), 0);
    rst = 1'b0;

    run(1'b0, 32'h12345678, 32'h12345679, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 4);
    run(1'b0, 32'hFF000000, 32'h00FFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1);
    run(1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1);
    run(1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1);
    run(1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 4);
    run(1'b1, 32'h00000800, 32'h000007FF, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1);
    run(1'b1, 32'h00000800, 32'h000007FF, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1);
    run(1'b1, 32'h00000123, 32'h00000123, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 3);

    @(negedge clk);
    ifa.req = 1'b1; ifa.x = 32'h00000005; ifa.y = 32'h00000003; ifa.sgn = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_fin", 32'(ifa.fin), 0);
    chk("abort_busy", 32'(ifa.busy), 0);
    chk("abort_flags", 32'(flags_of(1'b0)), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run(1'b0, 32'h00000005, 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
